// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - valid/ready bundle carrying raw immediates in and extended words out
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) ();
    logic [IN_W-1:0]  in;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in, mode, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in, mode, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender (sign/zero/upper/branch) with 2-entry output FIFO
// Optional negative-immediate counter enabled by defining IMM_EXT_STATS_EN.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    imm_extend_pipe_if.slave      bus
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [CNT_W-1:0]      neg_count
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_int;
    logic             out_valid_int;
    logic             acc;
    logic             rel;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] head_q;
    logic [OUT_W-1:0] skid_q;

    assign acc = bus.in_valid & in_ready_int;
    assign rel = out_valid_int & bus.out_ready;

    // Extension happens at accept time so the buffer only ever holds finished words.
    assign sext = {{(OUT_W-IN_W){bus.in[IN_W-1]}}, bus.in};

    always_comb begin
        ext = sext;
        case (bus.mode)
            2'b00:   ext = sext;
            2'b01:   ext = {{(OUT_W-IN_W){1'b0}}, bus.in};
            2'b10:   ext = {bus.in, {(OUT_W-IN_W){1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (acc)         state_d = S_ONE;
            S_ONE: begin
                if (acc && !rel)      state_d = S_FULL;
                else if (!acc && rel) state_d = S_EMPTY;
            end
            S_FULL:  if (rel)         state_d = S_ONE;
            default:                  state_d = S_EMPTY;
        endcase
    end

    // Handshake outputs depend on the registered state only, never on out_ready.
    always_comb begin
        in_ready_int  = 1'b1;
        out_valid_int = 1'b0;
        case (state_q)
            S_EMPTY: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
            end
            S_ONE: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b1;
            end
            S_FULL: begin
                in_ready_int  = 1'b0;
                out_valid_int = 1'b1;
            end
            default: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (acc && (state_q == S_EMPTY || (state_q == S_ONE && rel))) begin
                head_q <= ext;
            end else if (acc && state_q == S_ONE) begin
                skid_q <= ext;
            end else if (rel && state_q == S_FULL) begin
                head_q <= skid_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out       = head_q;

`ifdef IMM_EXT_STATS_EN
    logic neg_hit;

    assign neg_hit = acc && (bus.mode == 2'b00 || bus.mode == 2'b11) && bus.in[IN_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_count <= '0;
        end else if (neg_hit && (neg_count != {CNT_W{1'b1}})) begin
            neg_count <= neg_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    localparam int CNT_W_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed and random checks of imm_extend_pipe against a FIFO reference model
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    logic reset;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_extend_pipe_if #(.IN_W(10), .OUT_W(32)) b10 ();

`ifdef IMM_EXT_STATS_EN
    logic [1:0] neg_count;
    logic [1:0] neg_count10;
`endif

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef IMM_EXT_STATS_EN
        ,
        .neg_count (neg_count)
`endif
    );

    imm_extend_pipe #(.IN_W(10), .OUT_W(32), .CNT_W(2)) dut10 (
        .clk       (clk),
        .reset     (reset),
        .bus       (b10)
`ifdef IMM_EXT_STATS_EN
        ,
        .neg_count (neg_count10)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [31:0] last_out = '0;
    int negm = 0;

    function automatic logic [31:0] ref_ext(input int unsigned v, input int m, input int iw);
        longint sv;
        longint r;
        longint md;
        md = longint'(1) << 32;
        sv = (v >= (32'd1 << (iw - 1))) ? longint'(v) - (longint'(1) << iw) : longint'(v);
        case (m)
            0:       r = (sv + md) % md;
            1:       r = longint'(v);
            2:       r = longint'(v) * (longint'(1) << (32 - iw));
            default: r = (((sv * 4) % md) + md) % md;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] d, input logic [1:0] m, input bit ordy);
        bit acc;
        bit rel;
        bus.in        = d;
        bus.mode      = m;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        acc = v && (q.size() < 2);
        rel = ordy && (q.size() > 0);
        @(posedge clk);
        @(negedge clk);
        if (rel) void'(q.pop_front());
        if (acc) begin
            q.push_back(ref_ext(d, m, 16));
            if ((m == 2'b00 || m == 2'b11) && d[15] && negm < 3) negm++;
        end
        if (q.size() > 0) last_out = q[0];
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() != 2);
        chk("out", bus.out, last_out);
`ifdef IMM_EXT_STATS_EN
        chk("neg_count", neg_count, negm);
`endif
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out", bus.out, 32'h0);
        q.delete();
        last_out = '0;
        negm = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.in = '0; bus.mode = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        b10.in = '0; b10.mode = '0; b10.in_valid = 1'b0; b10.out_ready = 1'b1;
        #3;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_out", bus.out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 16'h0, 2'b00, 1);

        cycle(1, 16'h8001, 2'b00, 1);
        chk("sext_8001", bus.out, 32'hFFFF8001);
        cycle(1, 16'h8001, 2'b01, 1);
        chk("zext_8001", bus.out, 32'h00008001);
        cycle(1, 16'h1234, 2'b10, 1);
        chk("upper_1234", bus.out, 32'h12340000);
        cycle(1, 16'hFFFF, 2'b11, 1);
        chk("branch_ffff", bus.out, 32'hFFFFFFFC);
        cycle(0, 16'h0, 2'b00, 1);
        cycle(0, 16'h0, 2'b00, 1);

        cycle(1, 16'h0001, 2'b00, 0);
        cycle(1, 16'h0002, 2'b00, 0);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_head", bus.out, 32'h1);
        cycle(1, 16'h0003, 2'b00, 0);
        chk("bp_hold", bus.out, 32'h1);
        cycle(0, 16'h0, 2'b00, 1);
        chk("bp_second", bus.out, 32'h2);
        chk("bp_ready_back", bus.in_ready, 1'b1);
        cycle(0, 16'h0, 2'b00, 1);
        chk("bp_drained", bus.out_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            cycle(1, 16'(16'h0100 + i), 2'b01, 1);
            chk("stream_val", bus.out, 32'(32'h0100 + i));
        end
        cycle(0, 16'h0, 2'b00, 1);

        cycle(1, 16'hAAAA, 2'b00, 0);
        cycle(1, 16'h5555, 2'b00, 0);
        async_reset();
        cycle(0, 16'h0, 2'b00, 1);
        cycle(0, 16'h0, 2'b00, 1);
        chk("no_stale", bus.out_valid, 1'b0);

        for (int i = 0; i < 4; i++) cycle(1, 16'(16'h8000 + i), 2'b00, 1);
`ifdef IMM_EXT_STATS_EN
        chk("neg_sat", neg_count, 2'd3);
`endif
        cycle(1, 16'h8000, 2'b01, 1);
`ifdef IMM_EXT_STATS_EN
        chk("neg_mode01", neg_count, 2'd3);
`endif
        cycle(0, 16'h0, 2'b00, 1);

        b10.in = 10'h200; b10.mode = 2'b00; b10.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("w10_200", b10.out, ref_ext(32'h200, 0, 10));
        chk("w10_200_const", b10.out, 32'hFFFFFE00);
        b10.in = 10'h1FF;
        @(posedge clk); @(negedge clk);
        chk("w10_1ff", b10.out, 32'h000001FF);
        chk("w10_valid", b10.out_valid, 1'b1);
        b10.in_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 2'b00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
